md_seq_unit: RTL and testbench

- Multi-cycle sequencer for RISC-V M-extension ops (MUL/MULH/MULHSU/MULHU/DIV/DIVU/REM/REMU).
- Sits beside the single-cycle ALU in EX. Owns one shared shift-add / restoring-divide datapath and runs it over 32 iterations.
- Drives a busy/done handshake so the pipeline controller stalls EX until the result is ready.
- Fixed latency for every op, so stall logic and verification stay simple.

---
 rtl/md_pkg.sv | 35 +++
 rtl/md_iter_step.sv | 32 +++
 rtl/md_seq_unit.sv | 117 +++++++++++
 tb/tb_md_seq_unit.sv | 132 +++++++++++++
 4 files changed

// File: rtl/md_pkg.sv
// Shared definitions for the M-extension sequencer: funct3 codes, FSM states,
// and operand-signedness helpers.
package md_pkg;

  localparam int XLEN = 32;

  localparam logic [2:0] MD_MUL    = 3'b000;
  localparam logic [2:0] MD_MULH   = 3'b001;
  localparam logic [2:0] MD_MULHSU = 3'b010;
  localparam logic [2:0] MD_MULHU  = 3'b011;
  localparam logic [2:0] MD_DIV    = 3'b100;
  localparam logic [2:0] MD_DIVU   = 3'b101;
  localparam logic [2:0] MD_REM    = 3'b110;
  localparam logic [2:0] MD_REMU   = 3'b111;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_FIX  = 2'd2,
    S_DONE = 2'd3
  } md_state_e;

  function automatic logic op_is_div(input logic [2:0] op);
    return op[2];
  endfunction

  function automatic logic op_a_signed(input logic [2:0] op);
    return (op == MD_MULH) || (op == MD_MULHSU) || (op == MD_DIV) || (op == MD_REM);
  endfunction

  function automatic logic op_b_signed(input logic [2:0] op);
    return (op == MD_MULH) || (op == MD_DIV) || (op == MD_REM);
  endfunction

endpackage

// File: rtl/md_iter_step.sv
// One iteration of the shared datapath: shift-add for multiply (multiplier in
// the low half, shifting right) or restoring shift-subtract for divide.
module md_iter_step #(
  parameter int W = 32
) (
  input  logic [2*W-1:0] i_acc,
  input  logic [W-1:0]   i_opnd,
  input  logic           i_is_div,
  output logic [2*W-1:0] o_acc
);

  logic [W:0]   w_sum;
  logic [W:0]   w_rem_sh;
  logic         w_ge;
  logic [W-1:0] w_diff;

  always_comb begin
    // NOTE: every output gets a default first, so no path through the block can infer a latch.
    o_acc    = {i_acc[2*W-2:0], 1'b0};
    w_sum    = {1'b0, i_acc[2*W-1:W]} + (i_acc[0] ? {1'b0, i_opnd} : '0);
    w_rem_sh = i_acc[2*W-1:W-1];
    w_ge     = (w_rem_sh >= {1'b0, i_opnd});
    // When the trial succeeds the difference is below the divisor, so W bits hold it.
    w_diff   = w_rem_sh[W-1:0] - i_opnd;
    if (!i_is_div) begin
      o_acc = {w_sum, i_acc[W-1:1]};
    end else if (w_ge) begin
      o_acc = {w_diff, i_acc[W-2:0], 1'b1};
    end
  end

endmodule

// File: rtl/md_seq_unit.sv
// Fixed-latency multiply/divide sequencer: magnitudes run through 32 shared
// iterations, then one fix-up cycle applies signs and corner cases.
module md_seq_unit #(
  parameter int XLEN = md_pkg::XLEN,
  parameter int ITER = XLEN
) (
  input  logic            cpu_clk,
  input  logic            cpu_rst_n,
  input  logic            start,
  input  logic [2:0]      md_op,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  input  logic            flush,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] result
);
  import md_pkg::*;

  localparam int CW = $clog2(ITER);
  localparam logic [CW-1:0] CNT_LAST = CW'(ITER - 1);

  md_state_e         r_state, w_state_nxt;
  logic [2:0]        r_op;
  logic [2*XLEN-1:0] r_acc, w_acc_step;
  logic [XLEN-1:0]   r_opnd, r_a_raw, r_result;
  logic [CW-1:0]     r_cnt;
  logic              r_neg_hi, r_neg_rem, r_b_zero, r_ovf;

  logic              w_sa, w_sb;
  logic [XLEN-1:0]   w_abs_a, w_abs_b, w_quo, w_rem, w_fixed;
  logic [2*XLEN-1:0] w_prod;

  assign w_sa    = op_a_signed(md_op) & a[XLEN-1];
  assign w_sb    = op_b_signed(md_op) & b[XLEN-1];
  assign w_abs_a = w_sa ? -a : a;
  assign w_abs_b = w_sb ? -b : b;

  md_iter_step #(.W(XLEN)) u_step (
    .i_acc    (r_acc),
    .i_opnd   (r_opnd),
    .i_is_div (op_is_div(r_op)),
    .o_acc    (w_acc_step)
  );

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (start) w_state_nxt = S_CALC;
      S_CALC:  if (r_cnt == CNT_LAST) w_state_nxt = S_FIX;
      S_FIX:   w_state_nxt = S_DONE;
      S_DONE:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
    if (flush) w_state_nxt = S_IDLE;
  end

  // Quotient negates when operand signs differ; remainder follows the dividend.
  always_comb begin
    w_prod  = r_neg_hi  ? -r_acc              : r_acc;
    w_quo   = r_neg_hi  ? -r_acc[XLEN-1:0]    : r_acc[XLEN-1:0];
    w_rem   = r_neg_rem ? -r_acc[2*XLEN-1:XLEN] : r_acc[2*XLEN-1:XLEN];
    w_fixed = w_prod[2*XLEN-1:XLEN];
    case (r_op)
      MD_MUL:           w_fixed = w_prod[XLEN-1:0];
      MD_DIV, MD_DIVU:  w_fixed = r_b_zero ? '1 : (r_ovf ? {1'b1, {(XLEN-1){1'b0}}} : w_quo);
      MD_REM, MD_REMU:  w_fixed = r_b_zero ? r_a_raw : (r_ovf ? '0 : w_rem);
      default:          w_fixed = w_prod[2*XLEN-1:XLEN];
    endcase
  end

  always_ff @(posedge cpu_clk or negedge cpu_rst_n) begin
    if (!cpu_rst_n) begin
      r_state   <= S_IDLE;
      r_op      <= MD_MUL;
      r_acc     <= '0;
      r_opnd    <= '0;
      r_a_raw   <= '0;
      r_result  <= '0;
      r_cnt     <= '0;
      r_neg_hi  <= 1'b0;
      r_neg_rem <= 1'b0;
      r_b_zero  <= 1'b0;
      r_ovf     <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register updates from pre-edge values.
      r_state <= w_state_nxt;
      if (!flush) begin
        case (r_state)
          S_IDLE: if (start) begin
            r_op      <= md_op;
            r_acc     <= {{XLEN{1'b0}}, op_is_div(md_op) ? w_abs_a : w_abs_b};
            r_opnd    <= op_is_div(md_op) ? w_abs_b : w_abs_a;
            r_a_raw   <= a;
            r_cnt     <= '0;
            r_neg_hi  <= w_sa ^ w_sb;
            r_neg_rem <= w_sa;
            r_b_zero  <= (b == '0);
            r_ovf     <= ((md_op == MD_DIV) || (md_op == MD_REM)) &&
                         (a == {1'b1, {(XLEN-1){1'b0}}}) && (b == '1);
          end
          S_CALC: begin
            r_acc <= w_acc_step;
            r_cnt <= r_cnt + 1'b1;
          end
          S_FIX:   r_result <= w_fixed;
          default: ;
        endcase
      end
    end
  end

  assign busy   = (r_state != S_IDLE);
  assign done   = (r_state == S_DONE);
  assign result = r_result;

endmodule

// File: tb/tb_md_seq_unit.sv
// Directed bench for md_seq_unit: latency, busy/done timing, results for each
// op including corner cases, flush, ignored start and asynchronous reset.
module tb_md_seq_unit;
  import md_pkg::*;

  logic        cpu_clk = 1'b0;
  logic        cpu_rst_n = 1'b0;
  logic        start = 1'b0;
  logic [2:0]  md_op = 3'b000;
  logic [31:0] a = '0;
  logic [31:0] b = '0;
  logic        flush = 1'b0;
  logic        busy, done;
  logic [31:0] result;

  int          n_checks = 0;
  int          n_fail   = 0;
  logic [31:0] last_result = '0;

  md_seq_unit dut (
    .cpu_clk   (cpu_clk),
    .cpu_rst_n (cpu_rst_n),
    .start     (start),
    .md_op     (md_op),
    .a         (a),
    .b         (b),
    .flush     (flush),
    .busy      (busy),
    .done      (done),
    .result    (result)
  );

  always #5 cpu_clk = ~cpu_clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Start in cycle 0; cycle k is the period after the k-th following edge.
  // With poke set, a second start with new operands is driven while busy.
  task automatic run_op(input string tag, input logic [2:0] op,
                        input logic [31:0] va, input logic [31:0] vb,
                        input logic [31:0] exp, input bit poke);
    logic eb;
    @(negedge cpu_clk);
    md_op = op; a = va; b = vb; start = 1'b1;
    for (int k = 1; k <= 35; k++) begin
      @(posedge cpu_clk); #1;
      eb = (k <= 34);
      check($sformatf("%s busy c%0d", tag, k), {31'd0, busy}, {31'd0, eb});
      eb = (k == 34);
      check($sformatf("%s done c%0d", tag, k), {31'd0, done}, {31'd0, eb});
      if (k == 34) check($sformatf("%s result", tag), result, exp);
      start = poke && (k >= 4) && (k <= 6);
      if (poke) begin
        md_op = MD_MUL; a = $urandom; b = $urandom;
      end
    end
    start = 1'b0;
    last_result = exp;
  endtask

  initial begin
    #2;
    check("reset busy",   {31'd0, busy}, 32'd0);
    check("reset done",   {31'd0, done}, 32'd0);
    check("reset result", result, 32'd0);
    @(negedge cpu_clk);
    cpu_rst_n = 1'b1;
    @(negedge cpu_clk);

    run_op("MUL 7*-3",        MD_MUL,    32'd7,        32'hFFFFFFFD, 32'hFFFFFFEB, 1'b0);
    run_op("MULH min*min",    MD_MULH,   32'h80000000, 32'h80000000, 32'h40000000, 1'b0);
    run_op("MULHU 2^31*2^31", MD_MULHU,  32'h80000000, 32'h80000000, 32'h40000000, 1'b0);
    run_op("MULHSU -1*2",     MD_MULHSU, 32'hFFFFFFFF, 32'd2,        32'hFFFFFFFF, 1'b0);
    run_op("DIV -7/2",        MD_DIV,    32'hFFFFFFF9, 32'd2,        32'hFFFFFFFD, 1'b0);
    run_op("REM -7%2",        MD_REM,    32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 1'b0);
    run_op("DIVU 100/7",      MD_DIVU,   32'd100,      32'd7,        32'd14,       1'b0);
    run_op("REMU 100%7",      MD_REMU,   32'd100,      32'd7,        32'd2,        1'b0);
    run_op("DIV 5/0",         MD_DIV,    32'd5,        32'd0,        32'hFFFFFFFF, 1'b0);
    run_op("REM 5%0",         MD_REM,    32'd5,        32'd0,        32'd5,        1'b0);
    run_op("DIV ovf",         MD_DIV,    32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1'b0);
    run_op("REM ovf",         MD_REM,    32'h80000000, 32'hFFFFFFFF, 32'd0,        1'b0);
    run_op("MULHU big",       MD_MULHU,  32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 1'b0);

    // Flush mid-CALC: killed op never pulses done and leaves result alone.
    @(negedge cpu_clk);
    md_op = MD_MUL; a = 32'd3; b = 32'd4; start = 1'b1;
    for (int k = 1; k <= 11; k++) begin
      @(posedge cpu_clk); #1;
      start = 1'b0;
      check($sformatf("flush done c%0d", k), {31'd0, done}, 32'd0);
      if (k == 10) flush = 1'b1;
    end
    check("flush busy",   {31'd0, busy}, 32'd0);
    check("flush result", result, last_result);
    flush = 1'b0;
    run_op("DIVU 9/3 after flush", MD_DIVU, 32'd9, 32'd3, 32'd3, 1'b1);

    // Asynchronous reset mid-CALC, checked between clock edges.
    @(negedge cpu_clk);
    md_op = MD_MUL; a = 32'd5; b = 32'd6; start = 1'b1;
    @(posedge cpu_clk); #1;
    start = 1'b0;
    repeat (4) @(posedge cpu_clk);
    #3 cpu_rst_n = 1'b0;
    #1;
    check("async rst busy",   {31'd0, busy}, 32'd0);
    check("async rst done",   {31'd0, done}, 32'd0);
    check("async rst result", result, 32'd0);
    @(negedge cpu_clk);
    cpu_rst_n = 1'b1;

    // Flush and start together in IDLE: start is dropped.
    @(negedge cpu_clk);
    md_op = MD_DIVU; a = 32'd8; b = 32'd2; start = 1'b1; flush = 1'b1;
    @(posedge cpu_clk); #1;
    start = 1'b0; flush = 1'b0;
    check("flush+start busy", {31'd0, busy}, 32'd0);
    @(posedge cpu_clk); #1;
    check("flush+start busy later", {31'd0, busy}, 32'd0);
    check("flush+start result", result, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
